// File: rtl/iter_alu.sv
// iter_alu: execution ALU with single-cycle logic/arith ops and iterative SLL/SRL, valid/ready handshake; define ITER_ALU_FAST_SHIFT_EN for 4-bit shift steps
module iter_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int CTRL_WIDTH  = 3,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);
`ifdef ITER_ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [CTRL_WIDTH-1:0] OP_ADD = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] OP_SLL = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] OP_XOR = CTRL_WIDTH'(4);
  localparam logic [CTRL_WIDTH-1:0] OP_SRL = CTRL_WIDTH'(5);
  localparam logic [CTRL_WIDTH-1:0] OP_OR  = CTRL_WIDTH'(6);
  localparam logic [CTRL_WIDTH-1:0] OP_AND = CTRL_WIDTH'(7);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  work, op_res, shifted;
  logic [SHAMT_WIDTH-1:0] cnt, step, shamt;
  logic                   left, accept, is_shift;

  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = src_b[SHAMT_WIDTH-1:0];
  assign is_shift = alu_ctrl == OP_SLL || alu_ctrl == OP_SRL;

  // single-cycle ops; a shift only lands here with shamt 0, so it passes src_a through
  always_comb begin
    op_res = alu_ctrl == OP_ADD ? src_a + src_b :
             alu_ctrl == OP_SUB ? src_a - src_b :
             alu_ctrl == OP_XOR ? src_a ^ src_b :
             alu_ctrl == OP_OR  ? src_a | src_b :
             alu_ctrl == OP_AND ? src_a & src_b :
             is_shift           ? src_a : '0;
  end

  // one shift step: 4 bits while enough remain in fast mode, otherwise 1 bit
  always_comb begin
    step    = FAST && cnt >= SHAMT_WIDTH'(4) ? SHAMT_WIDTH'(4) : SHAMT_WIDTH'(1);
    shifted = left ? work << step : work >> step;
  end

  // handshake FSM with registered result/zero/out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      work      <= '0;
      left      <= 1'b0;
    end else if (accept) begin
      if (is_shift && shamt != '0) begin
        state     <= SHIFT;
        cnt       <= shamt;
        work      <= src_a;
        left      <= alu_ctrl == OP_SLL;
        out_valid <= 1'b0;
      end else begin
        state     <= DONE;
        result    <= op_res;
        zero      <= op_res == '0;
        out_valid <= 1'b1;
      end
    end else if (state == SHIFT) begin
      work <= shifted;
      cnt  <= cnt - step;
      if (cnt == step) begin
        state     <= DONE;
        result    <= shifted;
        zero      <= shifted == '0;
        out_valid <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: randomized self-checking bench for iter_alu against an arithmetic reference model
module tb_iter_alu;
  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, zero;
  logic [2:0]  alu_ctrl;
  logic [31:0] src_a, src_b, result;
  int checks = 0;
  int errors = 0;

  iter_alu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int n = int'(b[4:0]);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a << n;
      3'd4: return a ^ b;
      3'd5: return a >> n;
      3'd6: return a | b;
      3'd7: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] c, input logic [31:0] b);
    int n = int'(b[4:0]);
    if (c != 3'd2 && c != 3'd5) return 1;
`ifdef ITER_ALU_FAST_SHIFT_EN
    return 1 + n / 4 + n % 4;
`else
    return 1 + n;
`endif
  endfunction

  // issue one op from IDLE, junk the inputs after acceptance, time the result, then consume it
  task automatic do_op(input string tag, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] e;
    e = model(c, a, b);
    check({tag, "_ready"}, in_ready, 1);
    in_valid = 1; alu_ctrl = c; src_a = a; src_b = b;
    @(posedge clk); #1;
    in_valid = 0; alu_ctrl = 3'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      check({tag, "_busy_ready"}, in_ready, 0);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 0;
    check({tag, "_lat"}, lat, exp_lat(c, b));
    check({tag, "_res"}, result, e);
    check({tag, "_zero"}, zero, e == 0);
    @(posedge clk); #1;
    check({tag, "_drain"}, out_valid, 0);
  endtask

  initial begin
    int stale;
    rst_n = 0; in_valid = 0; out_ready = 1; alu_ctrl = 0; src_a = 0; src_b = 0;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_res", result, 0);
    check("rst_zero", zero, 1);
    check("rst_ready", in_ready, 1);
    rst_n = 1;
    @(posedge clk); #1;

    do_op("add", 3'd0, 32'h7FFFFFFF, 32'd1);
    do_op("sub0", 3'd1, 32'h1234, 32'h1234);
    do_op("sub1", 3'd1, 32'd0, 32'd1);
    do_op("sll5", 3'd2, 32'd1, 32'h25);
    do_op("srl31", 3'd5, 32'h80000000, 32'd31);
    do_op("srl0", 3'd5, 32'hDEADBEEF, 32'h20);
    do_op("unasg", 3'd3, 32'h55, 32'hAA);

    // backpressure then back-to-back accept on the release edge
    out_ready = 0; in_valid = 1; alu_ctrl = 3'd7; src_a = 32'hF0F0; src_b = 32'hFF00;
    @(posedge clk); #1;
    alu_ctrl = 3'd4; src_a = 32'h0FF0; src_b = 32'h00FF;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_res", result, 32'hF000);
      check("bp_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1; #1;
    check("rel_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    check("b2b_valid", out_valid, 1);
    check("b2b_res", result, 32'h0F0F);
    @(posedge clk); #1;
    check("b2b_drain", out_valid, 0);

    // asynchronous reset in the middle of a long shift
    in_valid = 1; alu_ctrl = 3'd2; src_a = 32'd1; src_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (4) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_res", result, 0);
    check("mrst_zero", zero, 1);
    #3 rst_n = 1;
    stale = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("mrst_stale", stale, 0);
    check("mrst_ready", in_ready, 1);

    for (int i = 0; i < 200; i++) begin
      logic [2:0] c;
      logic [31:0] a, b;
      c = 3'($urandom); a = $urandom; b = $urandom;
      if (i % 5 == 0) b = a;
      do_op("rnd", c, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Execution-stage ALU that consumes `alu_ctrl` from the ALU decoder together with the two operands.
- Returns a registered result and zero flag over a valid/ready handshake.
- Logic/arithmetic ops complete in one cycle.
- Shifts (SLL/SRL) run iteratively, one bit per cycle, so the block can replace the combinational barrel shifter when area matters.
- Sits between the decoder/operand-mux and the writeback/branch logic.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- CTRL_WIDTH, 3, width of `alu_ctrl`; must match the decoder output.
- SHAMT_WIDTH, 5, shift-amount bits taken from `src_b[SHAMT_WIDTH-1:0]`; equals log2(DATA_WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- alu_ctrl  in  CTRL_WIDTH  op select: 000 add, 001 sub, 010 sll, 011 unassigned, 100 xor, 101 srl, 110 or, 111 and.
- src_a  in  DATA_WIDTH  operand A; the value that is shifted.
- src_b  in  DATA_WIDTH  operand B; low SHAMT_WIDTH bits are the shift amount.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  DATA_WIDTH  registered result.
- zero  out  1  high when result == 0.

Behaviour:
- Interface decision: single clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset: state=IDLE, result=0, zero=1, out_valid=0, shift counter=0. Reset applies immediately, including mid-shift; the in-flight op is discarded and no output is produced for it.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. Operands and alu_ctrl are captured on that edge; inputs may change afterwards.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=out_ready.
- Transitions:
  - Accepted op is non-shift, or a shift with shamt=0 → DONE. Result is computed and registered on the accept edge; latency is 1 cycle.
  - Accepted op is sll/srl with shamt=n>0 → SHIFT. Counter=n, working reg=src_a.
  - SHIFT, each cycle: working reg shifts 1 bit (sll: left, zero-fill; srl: right, logical zero-fill), counter decrements. When the counter reaches 0 on that edge → DONE. out_valid rises n+1 cycles after the accept edge.
  - DONE && out_ready && !in_valid → IDLE.
  - DONE && out_ready && in_valid → back-to-back accept on the same edge. The next state follows the new op, with no bubble.
  - DONE && !out_ready → hold. result, zero and out_valid are stable, and no new op is accepted.
- Arithmetic: add/sub use modulo 2^DATA_WIDTH with carry/borrow discarded. Logical ops are bitwise.
- Code 011 (unassigned): result=0, zero=1, latency 1. Not an error.
- zero is registered with result and always equals (result==0).
- in_valid while busy (SHIFT): ignored, not queued. The upstream source must hold its request.
- Max latency: DATA_WIDTH cycles (shamt = DATA_WIDTH-1).

Optional Feature:
- Macro: ITER_ALU_FAST_SHIFT_EN.
- When defined: each SHIFT cycle moves 4 bits while counter ≥ 4, otherwise 1 bit. Latency = 1 + (n>>2) + (n&3) cycles. Results are identical to the 1-bit mode.
- When undefined: 1 bit per cycle, latency 1 + n.

Test Plan:
- Add: ctrl=000, a=0x7FFFFFFF, b=1 → out_valid one cycle after accept, result=0x80000000, zero=0.
- Sub: ctrl=001, a=b=0x1234 → result=0, zero=1, latency 1. Repeat with a=0, b=1 → result=0xFFFFFFFF.
- Shift left: ctrl=010, a=0x1, b=0x25 (shamt=5) → result=0x20, out_valid 6 cycles after accept (3 cycles with ITER_ALU_FAST_SHIFT_EN), in_ready=0 throughout SHIFT.
- Shift right: ctrl=101, a=0x80000000, b=31 → result=0x1, latency 32 (with macro: 1+7+3=11). shamt=0 → result=a, latency 1.
- Backpressure/back-to-back: hold out_ready=0 for 4 cycles after an and-op (a=0xF0F0, b=0xFF00) → result=0xF000 stable, in_ready=0. Then assert out_ready with a queued xor-op → xor accepted on the release edge, its result valid on the next cycle.
- Reset mid-shift: start sll shamt=20, pull rst_n low asynchronously at cycle 5 → out_valid=0, result=0, zero=1 immediately. After release, in_ready=1 and no stale result appears.
